// File: rtl/uart_pkg.sv
// uart_pkg: shared UART receiver types and timing constants.
//   state_t      receiver FSM states
//   OVERSAMPLE   ticks per bit
//   SAMPLE_*     tick_cnt values at which the line is sampled for majority vote
//   STOP_EVAL    tick_cnt at which the stop bit is judged (mid-bit, allows resync)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int STOP_EVAL  = 9;

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery handshake from the UART receiver to its consumer.
//   rx_data     received payload, stable while rx_valid
//   rx_valid    payload available
//   rx_ready    consumer accepts on valid && ready
//   parity_err  parity mismatch for current rx_data
//   frame_err   one-cycle pulse on a low stop bit
//   overrun     one-cycle pulse when a good frame is dropped
//   master = receiver side, slave = consumer side
interface uart_rx_if #(parameter int DATA_BITS = 8);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 parity_err;
    logic                 frame_err;
    logic                 overrun;

    modport master (output rx_data, rx_valid, parity_err, frame_err, overrun, input rx_ready);
    modport slave  (input rx_data, rx_valid, parity_err, frame_err, overrun, output rx_ready);

endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: N-flop synchronizer for an asynchronous input, resets to 1.
//   clk, rst_n  clock and asynchronous active-low reset
//   d           asynchronous input
//   q           synchronized output
module uart_rx_sync #(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff <= '1;
        else        ff <= {ff[N-2:0], d};
    end

    assign q = ff[N-1];

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with majority-vote sampling and valid/ready delivery.
//   clk, rst_n  clock and asynchronous active-low reset
//   tick_16x    one-clk strobe at 16x baud
//   rxd         asynchronous serial line, idles high
//   busy        FSM not idle
//   rx          delivery handshake and status (uart_rx_if master)
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_EN   = 0,
    parameter int PARITY_ODD  = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tick_16x,
    input  logic      rxd,
    output logic      busy,
    uart_rx_if.master rx
);

    logic                 rxd_s;
    state_t               state_q, state_d;
    logic [3:0]           tick_cnt, bit_cnt;
    logic [2:0]           samp;
    logic [DATA_BITS-1:0] shift_q, data_q;
    logic                 par_q, valid_q, perr_q, ferr_q, ovr_q;
    logic                 at_end, at_stop, maj, maj_now, last_bit, good, load, perr_d;

    uart_rx_sync #(.N(SYNC_STAGES)) u_sync (.clk(clk), .rst_n(rst_n), .d(rxd), .q(rxd_s));

    assign at_end   = tick_16x && tick_cnt == 4'(OVERSAMPLE - 1);
    assign at_stop  = tick_16x && tick_cnt == 4'(STOP_EVAL) && state_q == STOP;
    assign maj      = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    // Stop is judged on the tick of its third sample, so that sample is taken live.
    assign maj_now  = (samp[0] & samp[1]) | (samp[0] & rxd_s) | (samp[1] & rxd_s);
    assign last_bit = bit_cnt == 4'(DATA_BITS - 1);
    assign good     = at_stop && maj_now;
    assign load     = good && (!valid_q || rx.rx_ready);
    assign perr_d   = (PARITY_EN != 0) && (par_q ^ (^shift_q) ^ (PARITY_ODD != 0));

    always_comb begin
        state_d = state_q;
        if (tick_16x) begin
            case (state_q)
                IDLE:      state_d = rxd_s ? IDLE : START;
                START:     state_d = !at_end ? START : maj ? IDLE : DATA;
                DATA:      state_d = !(at_end && last_bit) ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
                PARITY:    state_d = at_end ? STOP : PARITY;
                STOP:      state_d = !at_stop ? STOP : maj_now ? IDLE : WAIT_HIGH;
                WAIT_HIGH: state_d = rxd_s ? IDLE : WAIT_HIGH;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            samp     <= '1;
            shift_q  <= '0;
            par_q    <= 1'b0;
            data_q   <= '0;
            perr_q   <= 1'b0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            if (tick_16x) tick_cnt <= state_q == IDLE ? 4'd0 : tick_cnt + 4'd1;
            if (tick_16x && tick_cnt inside {4'(SAMPLE_LO), 4'(SAMPLE_MID), 4'(SAMPLE_HI)})
                samp <= {samp[1:0], rxd_s};
            if (at_end) bit_cnt <= state_q == DATA ? bit_cnt + 4'd1 : 4'd0;
            if (at_end && state_q == DATA) shift_q <= {maj, shift_q[DATA_BITS-1:1]};
            if (at_end && state_q == PARITY) par_q <= maj;
            if (load) begin
                data_q <= shift_q;
                perr_q <= perr_d;
            end
            valid_q <= load || (valid_q && !rx.rx_ready);
            ferr_q  <= at_stop && !maj_now;
            ovr_q   <= good && !load;
        end
    end

    assign busy          = state_q != IDLE;
    assign rx.rx_data    = data_q;
    assign rx.rx_valid   = valid_q;
    assign rx.parity_err = perr_q;
    assign rx.frame_err  = ferr_q;
    assign rx.overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx in 8N1 (dut0) and 8E1 (dut1) configurations.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tick_16x = 1'b0;
    logic rxd0 = 1'b1;
    logic rxd1 = 1'b1;
    logic busy0, busy1;

    int total = 0;
    int bad = 0;
    int acc0 = 0, fe0 = 0, ov0 = 0, acc1 = 0, fe1 = 0, ov1 = 0;
    logic [7:0] last0 = '0, last1 = '0;
    logic       lperr0 = 1'b0, lperr1 = 1'b0;
    int a, f, o;

    uart_rx_if #(.DATA_BITS(8)) rx0 ();
    uart_rx_if #(.DATA_BITS(8)) rx1 ();

    uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rxd(rxd0), .busy(busy0), .rx(rx0)
    );

    uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tick_16x(tick_16x), .rxd(rxd1), .busy(busy1), .rx(rx1)
    );

    always #5 clk = ~clk;

    initial begin
        int ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            tick_16x = (ph == 0);
        end
    end

    always @(negedge clk) begin
        if (rx0.rx_valid && rx0.rx_ready) begin
            acc0++;
            last0 = rx0.rx_data;
            lperr0 = rx0.parity_err;
        end
        if (rx1.rx_valid && rx1.rx_ready) begin
            acc1++;
            last1 = rx1.rx_data;
            lperr1 = rx1.parity_err;
        end
        fe0 += int'(rx0.frame_err);
        ov0 += int'(rx0.overrun);
        fe1 += int'(rx1.frame_err);
        ov1 += int'(rx1.overrun);
    end

    initial begin
        #2000000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_rxd(input int d, input logic v);
        if (d == 0) rxd0 = v;
        else        rxd1 = v;
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input int d, input logic [11:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            set_rxd(d, b[i]);
            clks(64);
        end
        set_rxd(d, 1'b1);
    endtask

    task automatic send8n1(input logic [7:0] data, input logic stop);
        send_bits(0, {2'b11, stop, data, 1'b0}, 10);
    endtask

    task automatic send8e1(input logic [7:0] data, input logic par);
        send_bits(1, {1'b1, 1'b1, par, data, 1'b0}, 11);
    endtask

    initial begin
        rx0.rx_ready = 1'b1;
        rx1.rx_ready = 1'b1;
        clks(3);
        chk("rst_data", 32'(rx0.rx_data), 32'h0);
        chk("rst_valid", 32'(rx0.rx_valid), 32'h0);
        chk("rst_perr", 32'(rx1.parity_err), 32'h0);
        chk("rst_ferr", 32'(rx0.frame_err), 32'h0);
        chk("rst_ovr", 32'(rx0.overrun), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        rst_n = 1'b1;
        clks(10);

        a = acc0; f = fe0; o = ov0;
        send8n1(8'h55, 1'b1);
        clks(64);
        chk("f55_acc", 32'(acc0 - a), 32'd1);
        chk("f55_data", 32'(last0), 32'h55);
        chk("f55_perr", 32'(lperr0), 32'h0);
        chk("f55_ferr", 32'(fe0 - f), 32'd0);
        chk("f55_ovr", 32'(ov0 - o), 32'd0);

        a = acc1;
        send8e1(8'hA3, 1'b0);
        clks(64);
        chk("a3p0_acc", 32'(acc1 - a), 32'd1);
        chk("a3p0_data", 32'(last1), 32'hA3);
        chk("a3p0_perr", 32'(lperr1), 32'h0);
        send8e1(8'hA3, 1'b1);
        clks(64);
        chk("a3p1_acc", 32'(acc1 - a), 32'd2);
        chk("a3p1_data", 32'(last1), 32'hA3);
        chk("a3p1_perr", 32'(lperr1), 32'h1);
        chk("par_ferr", 32'(fe1), 32'd0);

        a = acc0; f = fe0;
        rxd0 = 1'b0;
        clks(12);
        chk("fs_busy_hi", 32'(busy0), 32'h1);
        clks(4);
        rxd0 = 1'b1;
        clks(100);
        chk("fs_busy_lo", 32'(busy0), 32'h0);
        chk("fs_acc", 32'(acc0 - a), 32'd0);
        chk("fs_ferr", 32'(fe0 - f), 32'd0);

        a = acc0; f = fe0;
        send_bits(0, {3'b000, 8'h3C, 1'b0}, 10);
        rxd0 = 1'b0;
        clks(64 * 30);
        rxd0 = 1'b1;
        clks(64);
        chk("brk_ferr", 32'(fe0 - f), 32'd1);
        chk("brk_acc", 32'(acc0 - a), 32'd0);
        send8n1(8'h81, 1'b1);
        clks(64);
        chk("f81_acc", 32'(acc0 - a), 32'd1);
        chk("f81_data", 32'(last0), 32'h81);

        a = acc0; o = ov0;
        @(posedge clk); #1 rx0.rx_ready = 1'b0;
        send8n1(8'h11, 1'b1);
        send8n1(8'h22, 1'b1);
        clks(64);
        chk("ovr_valid", 32'(rx0.rx_valid), 32'h1);
        chk("ovr_data", 32'(rx0.rx_data), 32'h11);
        chk("ovr_pulse", 32'(ov0 - o), 32'd1);
        chk("ovr_acc", 32'(acc0 - a), 32'd0);
        @(posedge clk); #1 rx0.rx_ready = 1'b1;
        clks(4);
        chk("ovr_acc1", 32'(acc0 - a), 32'd1);
        chk("ovr_last", 32'(last0), 32'h11);
        chk("ovr_vdrop", 32'(rx0.rx_valid), 32'h0);

        @(posedge clk); #1 rx0.rx_ready = 1'b0;
        send8n1(8'h5A, 1'b1);
        clks(64);
        chk("pre_valid", 32'(rx0.rx_valid), 32'h1);
        chk("pre_data", 32'(rx0.rx_data), 32'h5A);
        send_bits(0, {3'b000, 8'hC3, 1'b0}, 5);
        rxd0 = 1'b0;
        clks(32);
        chk("mid_busy", 32'(busy0), 32'h1);
        #2 rst_n = 1'b0;
        rxd0 = 1'b1;
        #1;
        chk("ar_valid", 32'(rx0.rx_valid), 32'h0);
        chk("ar_data", 32'(rx0.rx_data), 32'h0);
        chk("ar_busy", 32'(busy0), 32'h0);
        chk("ar_ferr", 32'(rx0.frame_err), 32'h0);
        chk("ar_ovr", 32'(rx0.overrun), 32'h0);
        chk("ar_perr", 32'(rx0.parity_err), 32'h0);
        clks(5);
        rst_n = 1'b1;
        rx0.rx_ready = 1'b1;
        a = acc0; f = fe0;
        clks(64 * 8);
        chk("ar_nodeliv", 32'(acc0 - a), 32'd0);
        chk("ar_noferr", 32'(fe0 - f), 32'd0);
        send8n1(8'hF0, 1'b1);
        clks(64);
        chk("fF0_acc", 32'(acc0 - a), 32'd1);
        chk("fF0_data", 32'(last0), 32'hF0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
